// File: rtl/pc_sequencer.sv
// pc_sequencer: architectural PC register and next-PC selection for the simple
// core. Handles compressed steps, misaligned-target traps, external redirects
// and a circular return-address stack that flags mispredicted returns.
module pc_sequencer #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     RAS_DEPTH    = 4,
  parameter bit              SUPPORT_C    = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            advance,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic [22:0]     cword,
  input  logic            is_compressed,
  input  logic            link_rd,
  input  logic            link_rs1,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] r,
  input  logic [3:0]      ZCNVFlags,
  input  logic [XLEN-1:0] trap_vec,
  output logic [XLEN-1:0] pc,
  output logic            misalign,
  output logic [XLEN-1:0] bad_target,
  output logic [XLEN-1:0] ras_top,
  output logic            ras_empty,
  output logic            ras_mispredict
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

  typedef enum logic [3:0] {
    T_LOAD   = 4'd0,
    T_IMM    = 4'd1,
    T_STORE  = 4'd2,
    T_REG    = 4'd3,
    T_LUI    = 4'd4,
    T_AUIPC  = 4'd5,
    T_BRANCH = 4'd6,
    T_JALR   = 4'd7,
    T_JAL    = 4'd8
  } itype_e;

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_bad_target;
  logic            r_misalign;
  logic            r_mispredict;
  logic [XLEN-1:0] r_ras [RAS_DEPTH];
  logic [PW-1:0]   r_ptr;     // next free slot; top entry sits at r_ptr-1
  logic [CW-1:0]   r_cnt;

  itype_e          w_type;
  logic [2:0]      w_fun3;
  logic            w_z, w_c, w_n, w_v;
  logic            w_taken;
  logic [XLEN-1:0] w_step;
  logic [XLEN-1:0] w_seq;
  logic [XLEN-1:0] w_target;
  logic            w_jump;
  logic            w_misal;
  logic            w_is_jal;
  logic            w_is_jalr;
  logic            w_push;
  logic            w_pop;
  logic [PW-1:0]   w_top_idx;
  logic            w_empty;
  logic            w_unused;

  assign w_type    = itype_e'(cword[3:0]);
  assign w_fun3    = cword[6:4];
  assign w_z       = ZCNVFlags[3];
  assign w_c       = ZCNVFlags[2];
  assign w_n       = ZCNVFlags[1];
  assign w_v       = ZCNVFlags[0];
  assign w_unused  = ^cword[22:7];
  assign w_is_jal  = (w_type == T_JAL);
  assign w_is_jalr = (w_type == T_JALR);
  assign w_top_idx = r_ptr - PW'(1);
  assign w_empty   = (r_cnt == '0);

  // Branch condition decode from fun3 and the ALU flags
  always_comb begin
    w_taken = 1'b0;
    case (w_fun3)
      3'b000:  w_taken = w_z;
      3'b001:  w_taken = ~w_z;
      3'b100:  w_taken = w_n ^ w_v;
      3'b101:  w_taken = ~(w_n ^ w_v);
      3'b110:  w_taken = w_c;
      3'b111:  w_taken = ~w_c;
      default: w_taken = 1'b0;
    endcase
  end

  // Next-PC target selection, alignment check and RAS operation decode
  always_comb begin
    w_step   = (SUPPORT_C && is_compressed) ? XLEN'(2) : XLEN'(4);
    w_seq    = r_pc + w_step;
    w_jump   = 1'b0;
    w_target = w_seq;
    if (w_is_jal) begin
      w_jump   = 1'b1;
      w_target = r_pc + imm;
    end else if (w_is_jalr) begin
      w_jump   = 1'b1;
      w_target = (r + imm) & ~XLEN'(1);
    end else if ((w_type == T_BRANCH) && w_taken) begin
      w_jump   = 1'b1;
      w_target = r_pc + imm;
    end
    w_misal = w_jump && !SUPPORT_C && w_target[1];
    w_push  = !w_misal && (w_is_jal || w_is_jalr) && link_rd;
    w_pop   = !w_misal && w_is_jalr && link_rs1 && !w_empty;
  end

  // PC, trap capture, pulse outputs and RAS state update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc         <= RESET_VECTOR;
      r_bad_target <= '0;
      r_misalign   <= 1'b0;
      r_mispredict <= 1'b0;
      r_ptr        <= '0;
      r_cnt        <= '0;
      for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
        r_ras[i] <= '0;
      end
    end else begin
      r_misalign   <= 1'b0;
      r_mispredict <= 1'b0;
      if (redirect) begin
        r_pc <= redirect_pc & ~XLEN'(1);
      end else if (!stall && advance) begin
        if (w_misal) begin
          r_pc         <= trap_vec;
          r_bad_target <= w_target;
          r_misalign   <= 1'b1;
        end else begin
          r_pc <= w_next_pc();
          if (w_pop) begin
            r_mispredict <= (r_ras[w_top_idx] != w_target);
          end
          // Pop-then-push collapses to overwriting the top in place
          if (w_pop && w_push) begin
            r_ras[w_top_idx] <= w_seq;
          end else if (w_push) begin
            r_ras[r_ptr] <= w_seq;
            r_ptr        <= r_ptr + PW'(1);
            if (r_cnt != CW'(RAS_DEPTH)) begin
              r_cnt <= r_cnt + CW'(1);
            end
          end else if (w_pop) begin
            r_ptr <= w_top_idx;
            r_cnt <= r_cnt - CW'(1);
          end
        end
      end
    end
  end

  function automatic logic [XLEN-1:0] w_next_pc();
    return w_jump ? w_target : w_seq;
  endfunction

  assign pc             = r_pc;
  assign misalign       = r_misalign;
  assign bad_target     = r_bad_target;
  assign ras_empty      = w_empty;
  assign ras_top        = w_empty ? '0 : r_ras[w_top_idx];
  assign ras_mispredict = r_mispredict;

endmodule
